uart_core: RTL

UART_CORE -- requirements
Module: uart_core

---
 rtl/uart_core.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_core.sv
// 8N1 UART with TX/RX byte FIFOs and a small register file (data, status, int-enable, divisor).
// The serial timing is clocked from clk. A divisor value below 4 is treated as 4.

module uart_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push in the same cycle that it pops.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end
endmodule

module uart_core #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_write,
    input  logic        io_read,
    input  logic [3:0]  io_addr,
    input  logic [15:0] io_wdata,
    output logic [15:0] io_rdata,
    input  logic        rx,
    output logic        tx,
    output logic        uart_intr
);
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [15:0] div_q, div_d, div_eff;
    logic [1:0]  int_en_q, int_en_d;
    logic        overrun_q, overrun_d;

    logic        tx_push, tx_pop, tx_full, tx_empty, tx_busy, tx_bit_end;
    logic [7:0]  tx_head;
    logic        rx_pop, rx_full, rx_empty;
    logic [7:0]  rx_head;

    state_t      tx_state_q;
    logic [15:0] tx_cnt_q, tx_div_q;
    logic [2:0]  tx_bit_q;
    logic [7:0]  tx_shift_q;
    logic        tx_q;

    state_t      rx_state_q;
    logic [15:0] rx_cnt_q, rx_div_q;
    logic [2:0]  rx_bit_q;
    logic [7:0]  rx_shift_q;
    logic        rx_push_q;
    logic        rx_meta_q, rx_sync_q, rx_prev_q;

    assign div_eff   = (div_q < 16'd4) ? 16'd4 : div_q;
    assign tx_push   = io_write && (io_addr == 4'd0);
    assign rx_pop    = io_read && (io_addr == 4'd0);
    assign tx_busy   = (tx_state_q != S_IDLE);
    assign tx        = tx_q;
    assign uart_intr = (int_en_q[0] && !rx_empty) || (int_en_q[1] && tx_empty);

    uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop),
        .wdata(io_wdata[7:0]), .rdata(tx_head), .full(tx_full), .empty(tx_empty)
    );

    uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .push(rx_push_q), .pop(rx_pop),
        .wdata(rx_shift_q), .rdata(rx_head), .full(rx_full), .empty(rx_empty)
    );

    always_comb begin
        case (io_addr)
            4'd0:    io_rdata = rx_empty ? 16'h0 : {8'h0, rx_head};
            4'd1:    io_rdata = {10'h0, overrun_q, tx_busy, tx_full, tx_empty, rx_full, !rx_empty};
            4'd2:    io_rdata = {14'h0, int_en_q};
            4'd3:    io_rdata = div_q;
            default: io_rdata = 16'h0;
        endcase
    end

    always_comb begin
        div_d     = div_q;
        int_en_d  = int_en_q;
        overrun_d = overrun_q;
        if (io_write) begin
            case (io_addr)
                4'd1:    if (io_wdata[5]) overrun_d = 1'b0;
                4'd2:    int_en_d = io_wdata[1:0];
                4'd3:    div_d = io_wdata;
                default: ;
            endcase
        end
        if (rx_push_q && rx_full && !rx_pop) overrun_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q     <= DIV_RESET;
            int_en_q  <= 2'b00;
            overrun_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            int_en_q  <= int_en_d;
            overrun_q <= overrun_d;
        end
    end

    // Each bit latches the current divisor, so divisor writes land on bit boundaries.
    assign tx_bit_end = (tx_cnt_q == tx_div_q - 16'd1);
    assign tx_pop     = !tx_empty &&
                        ((tx_state_q == S_IDLE) || ((tx_state_q == S_STOP) && tx_bit_end));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= 16'd0;
            tx_div_q   <= 16'd4;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            tx_q       <= 1'b1;
        end else if (tx_state_q == S_IDLE) begin
            if (!tx_empty) begin
                tx_state_q <= S_START;
                tx_shift_q <= tx_head;
                tx_cnt_q   <= 16'd0;
                tx_div_q   <= div_eff;
                tx_q       <= 1'b0;
            end
        end else if (!tx_bit_end) begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
        end else begin
            tx_cnt_q <= 16'd0;
            tx_div_q <= div_eff;
            case (tx_state_q)
                S_START: begin
                    tx_state_q <= S_DATA;
                    tx_bit_q   <= 3'd0;
                    tx_q       <= tx_shift_q[0];
                    tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                end
                S_DATA: begin
                    if (tx_bit_q == 3'd7) begin
                        tx_state_q <= S_STOP;
                        tx_q       <= 1'b1;
                    end else begin
                        tx_bit_q   <= tx_bit_q + 3'd1;
                        tx_q       <= tx_shift_q[0];
                        tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                    end
                end
                default: begin
                    if (!tx_empty) begin
                        tx_state_q <= S_START;
                        tx_shift_q <= tx_head;
                        tx_q       <= 1'b0;
                    end else begin
                        tx_state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // START samples at half a bit; later samples fall mid-bit, one divisor apart.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= 16'd0;
            rx_div_q   <= 16'd4;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_push_q  <= 1'b0;
        end else begin
            rx_push_q <= 1'b0;
            case (rx_state_q)
                S_IDLE: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        rx_state_q <= S_START;
                        rx_cnt_q   <= 16'd0;
                        rx_div_q   <= div_eff;
                    end
                end
                S_START: begin
                    if (rx_cnt_q == (rx_div_q >> 1) - 16'd1) begin
                        rx_cnt_q   <= 16'd0;
                        rx_div_q   <= div_eff;
                        rx_bit_q   <= 3'd0;
                        rx_state_q <= rx_sync_q ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
                S_DATA: begin
                    if (rx_cnt_q == rx_div_q - 16'd1) begin
                        rx_cnt_q   <= 16'd0;
                        rx_div_q   <= div_eff;
                        rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd7) rx_state_q <= S_STOP;
                        else                  rx_bit_q   <= rx_bit_q + 3'd1;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
                default: begin
                    if (rx_cnt_q == rx_div_q - 16'd1) begin
                        rx_cnt_q   <= 16'd0;
                        rx_push_q  <= rx_sync_q;
                        rx_state_q <= S_IDLE;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
            endcase
        end
    end
endmodule
